// File: rtl/signal_ctrl_pkg.sv
// Shared types and constants for the N-phase signal controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package signal_ctrl_pkg;

  typedef enum logic [1:0] {
    GREEN_BASE = 2'd0,
    GREEN_EXT  = 2'd1,
    YELLOW     = 2'd2,
    WALK       = 2'd3
  } state_e;

  localparam logic [1:0] SLOT_BASE = 2'd0;
  localparam logic [1:0] SLOT_EXT  = 2'd1;
  localparam logic [1:0] SLOT_YEL  = 2'd2;
  localparam logic [1:0] SLOT_WALK = 2'd3;

  localparam int unsigned DEF_BASE = 6;
  localparam int unsigned DEF_EXT  = 3;
  localparam int unsigned DEF_YEL  = 2;
  localparam int unsigned DEF_WALK = 3;

  // Default interval for a time-table slot; also used when a zero is written.
  function automatic int unsigned slot_default(input logic [1:0] slot);
    case (slot)
      SLOT_BASE: return DEF_BASE;
      SLOT_EXT:  return DEF_EXT;
      SLOT_YEL:  return DEF_YEL;
      default:   return DEF_WALK;
    endcase
  endfunction

endpackage

// File: rtl/phase_interval_timer.sv
// Interval timer: prescaler producing Tick every CLK_DIV cycles plus a tick down-counter.
// Latency: expired is high in the last cycle of a value*CLK_DIV cycle interval; start reloads next edge.
// Backpressure: none; free-running, start always wins.
module phase_interval_timer #(
  parameter int                TIME_W      = 4,
  parameter int                CLK_DIV     = 4,
  parameter logic [TIME_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [TIME_W-1:0] value,
  output logic              Tick,
  output logic              expired
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;

  // Next-state: prescaler wraps at CLK_DIV-1, counter steps on each tick, start restarts both.
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (start) begin
      presc_d = '0;
      cnt_d   = value;
    end
    // Tick is registered, so it is decided from the prescaler value of the coming cycle.
    tick_d = (presc_d == PRESC_MAX);
  end

  // State registers; the reset interval matches the first state entered after reset.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q <= '0;
      cnt_q   <= RESET_VALUE;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign Tick    = tick_q;
  assign expired = tick_q && (cnt_q <= TIME_W'(1));

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// N-phase round-robin signal controller with per-phase green/extension/yellow/walk intervals.
// Latency: async inputs act 3 cycles after they change (2-flop sync + edge/latch); lamps registered.
// Backpressure: none; Reprogram strobes are taken on every synchronized rising edge.
module multi_phase_signal_ctrl
  import signal_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TIME_W     = 4,
  parameter int CLK_DIV    = 100_000_000,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic [NUM_PHASES-1:0] Sensor,
  input  logic [NUM_PHASES-1:0] Walk_Request,
  input  logic                  Reprogram,
  input  logic [PH_W-1:0]       Time_Phase_Selector,
  input  logic [1:0]            Time_Parameter_Selector,
  input  logic [TIME_W-1:0]     Time_Value,
  output logic [NUM_PHASES-1:0] Green,
  output logic [NUM_PHASES-1:0] Yellow,
  output logic [NUM_PHASES-1:0] Walk,
  output logic [PH_W-1:0]       Phase,
  output logic                  Tick
);

  logic [NUM_PHASES-1:0] sens_s1_q, sens_s2_q;
  logic [NUM_PHASES-1:0] walk_s1_q, walk_s2_q;
  logic                  rp_s1_q, rp_s2_q, rp_s3_q;
  logic                  rp_edge;

  logic [TIME_W-1:0]     tbl_q [NUM_PHASES][4];
  logic                  wr_en;
  logic [TIME_W-1:0]     wr_val;

  logic [NUM_PHASES-1:0] walk_latch_q;
  logic [NUM_PHASES-1:0] walk_clr;

  state_e                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d, phase_nxt;
  logic [NUM_PHASES-1:0] green_q, green_d, yellow_q, yellow_d, walk_q, walk_d;

  logic                  tmr_start, tmr_expired;
  logic [TIME_W-1:0]     tmr_value;

  // Two-flop synchronizers for the asynchronous inputs, plus a third Reprogram flop for edge detect.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sens_s1_q <= '0;
      sens_s2_q <= '0;
      walk_s1_q <= '0;
      walk_s2_q <= '0;
      rp_s1_q   <= 1'b0;
      rp_s2_q   <= 1'b0;
      rp_s3_q   <= 1'b0;
    end else begin
      sens_s1_q <= Sensor;
      sens_s2_q <= sens_s1_q;
      walk_s1_q <= Walk_Request;
      walk_s2_q <= walk_s1_q;
      rp_s1_q   <= Reprogram;
      rp_s2_q   <= rp_s1_q;
      rp_s3_q   <= rp_s2_q;
    end
  end

  assign rp_edge = rp_s2_q && !rp_s3_q;

  // Selector and value are sampled directly; they are expected to be stable around the strobe.
  assign wr_en  = rp_edge && (int'(Time_Phase_Selector) < NUM_PHASES);
  assign wr_val = (Time_Value == '0) ? TIME_W'(slot_default(Time_Parameter_Selector)) : Time_Value;

  // Time table: defaults at reset, one slot written per Reprogram rising edge.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        for (int s = 0; s < 4; s++) begin
          tbl_q[p][s] <= TIME_W'(slot_default(2'(s)));
        end
      end
    end else if (wr_en) begin
      tbl_q[Time_Phase_Selector][Time_Parameter_Selector] <= wr_val;
    end
  end

  // Walk latches: a request seen in the same cycle as the clear wins, so it is served next visit.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      walk_latch_q <= '0;
    end else begin
      walk_latch_q <= walk_s2_q | (walk_latch_q & ~walk_clr);
    end
  end

  assign phase_nxt = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;

  // Sequencer next-state, timer reload and lamp next-state; Reprogram restart has priority.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tmr_start = 1'b0;
    tmr_value = '0;
    walk_clr  = '0;
    if (rp_edge) begin
      state_d   = GREEN_BASE;
      phase_d   = '0;
      tmr_start = 1'b1;
      // The table write lands on the same edge, so bypass it when base(0) is the slot written.
      if (wr_en && (Time_Phase_Selector == '0) && (Time_Parameter_Selector == SLOT_BASE)) begin
        tmr_value = wr_val;
      end else begin
        tmr_value = tbl_q[0][SLOT_BASE];
      end
    end else if (tmr_expired) begin
      tmr_start = 1'b1;
      unique case (state_q)
        GREEN_BASE: begin
          if (sens_s2_q[phase_q]) begin
            state_d   = GREEN_EXT;
            tmr_value = tbl_q[phase_q][SLOT_EXT];
          end else begin
            state_d   = YELLOW;
            tmr_value = tbl_q[phase_q][SLOT_YEL];
          end
        end
        GREEN_EXT: begin
          state_d   = YELLOW;
          tmr_value = tbl_q[phase_q][SLOT_YEL];
        end
        YELLOW: begin
          if (walk_latch_q[phase_q]) begin
            state_d           = WALK;
            tmr_value         = tbl_q[phase_q][SLOT_WALK];
            walk_clr[phase_q] = 1'b1;
          end else begin
            state_d   = GREEN_BASE;
            phase_d   = phase_nxt;
            tmr_value = tbl_q[phase_nxt][SLOT_BASE];
          end
        end
        WALK: begin
          state_d   = GREEN_BASE;
          phase_d   = phase_nxt;
          tmr_value = tbl_q[phase_nxt][SLOT_BASE];
        end
      endcase
    end
    green_d  = ((state_d == GREEN_BASE) || (state_d == GREEN_EXT)) ? (NUM_PHASES'(1) << phase_d) : '0;
    yellow_d = (state_d == YELLOW) ? (NUM_PHASES'(1) << phase_d) : '0;
    walk_d   = (state_d == WALK)   ? (NUM_PHASES'(1) << phase_d) : '0;
  end

  // Sequencer state and registered lamp outputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= GREEN_BASE;
      phase_q  <= '0;
      green_q  <= NUM_PHASES'(1);
      yellow_q <= '0;
      walk_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      walk_q   <= walk_d;
    end
  end

  phase_interval_timer #(
    .TIME_W      (TIME_W),
    .CLK_DIV     (CLK_DIV),
    .RESET_VALUE (TIME_W'(DEF_BASE))
  ) u_timer (
    .clk     (clk),
    .Reset_n (Reset_n),
    .start   (tmr_start),
    .value   (tmr_value),
    .Tick    (Tick),
    .expired (tmr_expired)
  );

  assign Green  = green_q;
  assign Yellow = yellow_q;
  assign Walk   = walk_q;
  assign Phase  = phase_q;

endmodule

// File: doc/multi_phase_signal_ctrl.md
# multi_phase_signal_ctrl

Parametrised N-phase traffic-signal controller: the next generation of the two-road controller. It sequences any number of approaches round-robin with per-phase programmable green, extension, yellow and walk intervals. Walk requests are latched per phase, and each phase has its own vehicle sensor. Sits at the top of the signal datapath and drives lamp outputs directly; all timing is derived from `clk` through an internal prescaler.

## Interface
Parameters:
- `NUM_PHASES`, 2: number of approaches; must be ≥ 2.
- `TIME_W`, 4: width of interval values, in ticks.
- `CLK_DIV`, 100_000_000: `clk` cycles per tick, nominally 1 s.
- `PH_W`, `$clog2(NUM_PHASES)`: width of the phase index (derived).

Ports:
- `clk` in 1: single system clock.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `Sensor` in `NUM_PHASES`: per-phase vehicle presence, asynchronous level.
- `Walk_Request` in `NUM_PHASES`: per-phase pedestrian button, asynchronous level.
- `Reprogram` in 1: write strobe, asynchronous level; acts on its rising edge.
- `Time_Phase_Selector` in `PH_W`: phase slot to program.
- `Time_Parameter_Selector` in 2: slot select. 0 = base green, 1 = extension, 2 = yellow, 3 = walk.
- `Time_Value` in `TIME_W`: value to write.
- `Green` out `NUM_PHASES`: one-hot or zero.
- `Yellow` out `NUM_PHASES`: one-hot or zero.
- `Walk` out `NUM_PHASES`: one-hot or zero.
- `Phase` out `PH_W`: current phase index.
- `Tick` out 1: one-cycle pulse at each tick.

Red is implied for any phase whose `Green` and `Yellow` bits are both low.

## Operation
- Inputs `Sensor`, `Walk_Request` and `Reprogram` each pass through a 2-flop synchronizer.
- Time table: `NUM_PHASES`×4 registers of width `TIME_W`.
  - Reset defaults: base 6, extension 3, yellow 2, walk 3.
  - A write of value 0 restores that slot's default.
- Each phase p runs this sequence:
  - GREEN_BASE: `Green[p]`=1, lasts base(p) ticks.
  - If the synchronized `Sensor[p]`=1 in the expiry cycle, go to GREEN_EXT: `Green[p]`=1, lasts ext(p) ticks. Extension is granted at most once per visit. Otherwise go straight to YELLOW.
  - YELLOW: `Yellow[p]`=1, lasts yellow(p).
  - If walk latch p is set, go to WALK: all `Green`/`Yellow` low, `Walk[p]`=1, lasts walk(p). Otherwise skip WALK.
  - Then move to GREEN_BASE of phase (p+1) mod `NUM_PHASES`.
- Walk latch: one per phase.
  - Set while synchronized `Walk_Request[i]`=1.
  - Cleared on the cycle WALK(i) is entered.
  - Simultaneous set and clear: set wins, so the request is served on the next visit.
- Reprogram rising edge:
  - Writes the selected slot.
  - Forces GREEN_BASE of phase 0 with a fresh timer, using the newly written value if that slot was base(0).
  - Walk latches are preserved.
- Out-of-range `Time_Phase_Selector` (≥`NUM_PHASES`): the write is ignored, but the restart still occurs.

## Timing
- Reset values:
  - `Phase`=0, state GREEN_BASE, `Green`=1 (bit 0 only).
  - `Yellow`=0, `Walk`=0, `Tick`=0.
  - Latches clear, table at defaults, prescaler 0.
- The prescaler restarts on every state entry. A state of value v therefore lasts exactly v×`CLK_DIV` cycles.
- `Tick` pulses in cycle `CLK_DIV`−1 of each period. The state changes on the edge following the v-th tick, and new outputs are visible that cycle. All outputs are registered.
- Input-to-action latency is 2 cycles through the synchronizer, plus 1 cycle for edge detect/latch.
- Reset assertion mid-interval returns every register to its reset value immediately; no partial state survives.

## Structure
- Package `signal_ctrl_pkg`:
  - State enum: GREEN_BASE, GREEN_EXT, YELLOW, WALK.
  - Slot constants: SLOT_BASE=0, SLOT_EXT=1, SLOT_YEL=2, SLOT_WALK=3.
  - Default-value constants.
- Sub-module `phase_interval_timer`:
  - Prescaler plus `TIME_W` down-counter.
  - Inputs: `start`, `value`.
  - Outputs: `Tick`, `expired`.
- Top level holds the synchronizers, time table, walk latches and FSM.

## Test plan
All scenarios use `CLK_DIV`=4.
- Reset, `NUM_PHASES`=3, no inputs: `Green` 001 for 24 cycles, `Yellow` 001 for 8, then `Green` 010; full cycle = 3×32 = 96 cycles.
- `Sensor[0]`=1 held through base expiry: `Green[0]` lasts (6+3)×4 = 36 cycles; extension occurs only once.
- `Walk_Request[1]` pulsed for 3 cycles during phase 0: after `Yellow[1]`, `Walk`=010 for 12 cycles with lamps dark; the following cycle omits WALK.
- Reprogram phase 1, slot 2, value 5, mid phase 1: restart at `Green`=001; `Yellow[1]` later lasts 20 cycles. Writing value 0 restores 8 cycles.
- Walk request re-asserted in the WALK-entry cycle: latch remains set and walk is served again next visit.
- `Reset_n` low mid-GREEN_EXT for 1 cycle: outputs return to reset values asynchronously, and the 24-cycle base green restarts.
